// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table, filter state type and segment-to-hex decode helper.
package seg7_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic {WAIT_STABLE, ACCEPTED} filt_state_e;
  function automatic logic [4:0] seg7_to_hex(input logic [SEG_W-1:0] seg);
    seg7_to_hex = '0;
    for (int i = 0; i < 16; i++)
      if (seg == GLYPH[i]) seg7_to_hex = {1'b1, 4'(i)};
  endfunction
endpackage

// File: rtl/seg7_reader_if.sv
// seg7_reader_if: display drive lines plus recovered word/error outputs.
interface seg7_reader_if import seg7_pkg::*; #(parameter int NUM_DIGITS = 4);
  logic [SEG_W-1:0] seg_in;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic [4*NUM_DIGITS-1:0] value_out;
  logic value_valid;
  logic pattern_err;
  logic [NUM_DIGITS-1:0] err_digit;
  modport master(output seg_in, dig_sel, input value_out, value_valid, pattern_err, err_digit);
  modport slave(input seg_in, dig_sel, output value_out, value_valid, pattern_err, err_digit);
endinterface

// File: rtl/seg7_stable_filter.sv
// seg7_stable_filter: samples {sel,seg}, requires a stable window, strobes accept once per held pattern.
module seg7_stable_filter import seg7_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0] dig_sel,
  output logic accept,
  output logic [SEG_W-1:0] seg,
  output logic [NUM_DIGITS-1:0] sel
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] TOP = CW'(STABLE_CYCLES - 1);
  filt_state_e state;
  logic [CW-1:0] cnt;
  logic changed;
  assign changed = {dig_sel, seg_in} != {sel, seg};
  // accept is decoded from registers only, so the top acts on the same edge the FSM leaves WAIT_STABLE
  assign accept = state == WAIT_STABLE && cnt == TOP && $onehot(sel);
  always_ff @(posedge clk)
    if (rst) begin
      sel <= '0;
      seg <= '0;
      cnt <= '0;
      state <= WAIT_STABLE;
    end else begin
      {sel, seg} <= {dig_sel, seg_in};
      cnt <= changed ? '0 : cnt == TOP ? cnt : cnt + 1'b1;
      state <= changed ? WAIT_STABLE : accept ? ACCEPTED : state;
    end
endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: recovers hex nibbles from a multiplexed 7-segment drive and assembles full words.
module seg7_reader import seg7_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  seg7_reader_if.slave bus
);
  logic accept, wr, bad;
  logic [SEG_W-1:0] seg;
  logic [NUM_DIGITS-1:0] sel, mask;
  logic [4:0] dec;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
  seg7_stable_filter #(.NUM_DIGITS(NUM_DIGITS), .STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk(clk), .rst(rst), .seg_in(bus.seg_in), .dig_sel(bus.dig_sel),
    .accept(accept), .seg(seg), .sel(sel)
  );
  assign dec = seg7_to_hex(seg);
  assign wr = accept & dec[4];
  assign bad = accept & ~dec[4];
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sel[i]) shadow_nxt[4*i +: 4] = dec[3:0];
  end
  always_ff @(posedge clk)
    if (rst) begin
      shadow <= '0;
      mask <= '0;
      bus.value_out <= '0;
      bus.value_valid <= 1'b0;
      bus.pattern_err <= 1'b0;
      bus.err_digit <= '0;
    end else begin
      if (wr) shadow <= shadow_nxt;
      // a capture landing on the completion edge starts the next frame
      mask <= (&mask ? '0 : mask) | (wr ? sel : '0);
      bus.value_valid <= &mask;
      if (&mask) bus.value_out <= shadow;
      bus.pattern_err <= bad;
      if (bad) bus.err_digit <= sel;
    end
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: table-driven digit sequences with word/error scoreboards.
module tb_seg7_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int nvalid = 0;
  logic [15:0] wq[$];
  logic [3:0] eq[$];
  seg7_reader_if #(.NUM_DIGITS(4)) bus ();
  seg7_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    int hold;
    logic err;
    logic done;
    logic [15:0] word;
  } step_t;
  step_t tbl[$];

  function automatic step_t s(logic [3:0] sel, logic [6:0] seg, int hold, logic err, logic done, logic [15:0] word);
    step_t r;
    r.sel = sel; r.seg = seg; r.hold = hold; r.err = err; r.done = done; r.word = word;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(logic [3:0] sel, logic [6:0] seg, int n);
    bus.dig_sel = sel;
    bus.seg_in = seg;
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) if (!rst) begin
    if (bus.value_valid) begin
      nvalid++;
      if (wq.size() == 0) chk("unexpected value_valid", {16'h0, bus.value_out}, 32'hFFFF_FFFF);
      else chk("value_out", {16'h0, bus.value_out}, {16'h0, wq.pop_front()});
    end
    if (bus.pattern_err) begin
      if (eq.size() == 0) chk("unexpected pattern_err", {28'h0, bus.err_digit}, 32'hFFFF_FFFF);
      else chk("err_digit", {28'h0, bus.err_digit}, {28'h0, eq.pop_front()});
    end
  end

  initial begin
    tbl.push_back(s(4'b0001, 7'h71, 8, 0, 0, 0));
    tbl.push_back(s(4'b0010, 7'h77, 8, 0, 0, 0));
    tbl.push_back(s(4'b0100, 7'h5B, 8, 0, 0, 0));
    tbl.push_back(s(4'b1000, 7'h06, 8, 0, 1, 16'h12AF));
    tbl.push_back(s(4'b0001, 7'h3F, 8, 0, 0, 0));
    tbl.push_back(s(4'b0010, 7'h06, 8, 0, 0, 0));
    tbl.push_back(s(4'b0100, 7'h3F, 3, 0, 0, 0));
    tbl.push_back(s(4'b0100, 7'h4F, 8, 0, 0, 0));
    tbl.push_back(s(4'b1000, 7'h7F, 8, 0, 1, 16'h8310));
    tbl.push_back(s(4'b0001, 7'h6D, 8, 0, 0, 0));
    tbl.push_back(s(4'b0010, 7'h40, 8, 1, 0, 0));
    tbl.push_back(s(4'b0010, 7'h7D, 8, 0, 0, 0));
    tbl.push_back(s(4'b0100, 7'h07, 8, 0, 0, 0));
    tbl.push_back(s(4'b1000, 7'h66, 8, 0, 1, 16'h4765));
    tbl.push_back(s(4'b0110, 7'h3F, 8, 0, 0, 0));
    tbl.push_back(s(4'b0000, 7'h3F, 8, 0, 0, 0));
    tbl.push_back(s(4'b0001, 7'h6F, 8, 0, 0, 0));
    tbl.push_back(s(4'b0010, 7'h7C, 8, 0, 0, 0));
    tbl.push_back(s(4'b0100, 7'h39, 8, 0, 0, 0));
    tbl.push_back(s(4'b1000, 7'h5E, 8, 0, 1, 16'hDCB9));
    tbl.push_back(s(4'b0001, 7'h79, 8, 0, 0, 0));
    tbl.push_back(s(4'b0010, 7'h4F, 8, 0, 0, 0));
    tbl.push_back(s(4'b0100, 7'h66, 8, 0, 0, 0));
    tbl.push_back(s(4'b1000, 7'h6D, 8, 0, 1, 16'h543E));
    tbl.push_back(s(4'b0001, 7'h06, 8, 0, 0, 0));
    tbl.push_back(s(4'b0001, 7'h5B, 8, 0, 0, 0));
    tbl.push_back(s(4'b1000, 7'h00, 8, 1, 0, 0));
    tbl.push_back(s(4'b0010, 7'h07, 8, 0, 0, 0));
    tbl.push_back(s(4'b0100, 7'h7F, 8, 0, 0, 0));
    tbl.push_back(s(4'b1000, 7'h71, 8, 0, 1, 16'hF872));

    rst = 1'b1;
    bus.seg_in = 7'($urandom);
    bus.dig_sel = 4'($urandom);
    @(posedge clk); #2;
    bus.seg_in = 7'($urandom);
    bus.dig_sel = 4'($urandom);
    @(posedge clk);
    @(negedge clk);
    chk("reset value_out", {16'h0, bus.value_out}, 32'h0);
    chk("reset value_valid", {31'h0, bus.value_valid}, 32'h0);
    chk("reset pattern_err", {31'h0, bus.pattern_err}, 32'h0);
    chk("reset err_digit", {28'h0, bus.err_digit}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    apply(4'b0000, 7'h00, 10);
    chk("no value_valid after reset", nvalid, 0);

    foreach (tbl[i]) begin
      if (tbl[i].err) eq.push_back(tbl[i].sel);
      if (tbl[i].done) wq.push_back(tbl[i].word);
      apply(tbl[i].sel, tbl[i].seg, tbl[i].hold);
    end
    chk("frames seen", nvalid, 6);

    apply(4'b0010, 7'h06, 8);
    apply(4'b0100, 7'h06, 8);
    apply(4'b1000, 7'h06, 8);
    rst = 1'b1;
    apply(4'b0000, 7'h00, 2);
    @(negedge clk);
    chk("mid reset value_out", {16'h0, bus.value_out}, 32'h0);
    chk("mid reset err_digit", {28'h0, bus.err_digit}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    nvalid = 0;
    wq.push_back(16'h8888);
    apply(4'b0001, 7'h7F, 40);
    apply(4'b0010, 7'h7F, 8);
    apply(4'b0100, 7'h7F, 8);
    apply(4'b1000, 7'h7F, 8);
    apply(4'b0000, 7'h00, 10);
    chk("single frame after reset", nvalid, 1);
    chk("word queue drained", wq.size(), 0);
    chk("error queue drained", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
